// File: rtl/finv_iter_for_fdiv.sv
// finv_iter_for_fdiv: reciprocal of the divisor mantissa for a single-precision
// divider. The fraction of y2 approximates 1/(1.m2) scaled by two, and the sign
// and exponent of x2 pass through, so the downstream multiplier can form
// x1 * y2 without touching the exponent path.
//
// q = floor(2^47 / {1,m2}) is produced by restoring division, one quotient bit
// per cycle, MSB first. One extra cycle after the 24th bit assembles y2,
// including saturation for m2 == 0. This gives a fixed 25-cycle latency from
// the accepting edge to out_valid.
module finv_iter_for_fdiv (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y1,
  output logic [31:0] y2
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q;
  logic [4:0]  cnt_q;
  logic [24:0] rem_q;
  logic [23:0] quo_q;
  logic [23:0] div_q;
  logic [31:0] x1_q;
  logic [8:0]  se2_q;
  logic        in_ready_q;
  logic        out_valid_q;
  logic [31:0] y1_q;
  logic [31:0] y2_q;

  logic        rem_ge_s;
  logic [24:0] rem_sub_s;
  logic [24:0] rem_d;
  logic [23:0] quo_d;
  logic [22:0] r_s;

  // One restoring-division step plus the saturating fraction select.
  always_comb begin
    rem_ge_s  = 1'b0;
    rem_sub_s = 25'd0;
    rem_d     = 25'd0;
    quo_d     = 24'd0;
    r_s       = 23'd0;

    rem_ge_s = (rem_q >= {1'b0, div_q});
    if (rem_ge_s) begin
      rem_sub_s = rem_q - {1'b0, div_q};
    end else begin
      rem_sub_s = rem_q;
    end
    // After a step the remainder is below D < 2^24, so the shift never overflows.
    rem_d = rem_sub_s << 1;
    quo_d = {quo_q[22:0], rem_ge_s};

    // For m2 == 0 the true quotient is 2^24, which does not fit; clamp to all ones.
    // A valid D always gives quotient bit 23 set, so a clear bit also clamps.
    if ((div_q[22:0] == 23'd0) || !quo_q[23]) begin
      r_s = 23'h7F_FFFF;
    end else begin
      r_s = quo_q[22:0];
    end
  end

  // Control FSM with operand capture, iteration state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 5'd0;
      rem_q       <= 25'd0;
      quo_q       <= 24'd0;
      div_q       <= 24'd0;
      x1_q        <= 32'd0;
      se2_q       <= 9'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      y1_q        <= 32'd0;
      y2_q        <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            x1_q       <= x1;
            se2_q      <= x2[31:23];
            div_q      <= {1'b1, x2[22:0]};
            rem_q      <= 25'h100_0000;
            quo_q      <= 24'd0;
            cnt_q      <= 5'd0;
            in_ready_q <= 1'b0;
            state_q    <= CALC;
          end
        end
        CALC: begin
          // Counts 0..23 each retire one quotient bit; count 24 publishes the result.
          if (cnt_q == 5'd24) begin
            y1_q        <= x1_q;
            y2_q        <= {se2_q, r_s};
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q + 5'd1;
          end
        end
        DONE: begin
          // in_ready rises only after the consuming edge, never in the same cycle.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign y1        = y1_q;
  assign y2        = y2_q;

endmodule
